// File: rtl/mandelbrot_lanes_if.sv
// Pixel stream from the lane engines to the pixel buffer / VGA path.
// The master drives the pixel and valid; the slave drives ready.
interface mandelbrot_lanes_if #(
  parameter int unsigned OUTWIDTH = 4,
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 240
);
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                out_valid;
  logic                out_ready;
  logic [OUTWIDTH-1:0] out_ctr;
  logic [XW-1:0]       out_x;
  logic [YW-1:0]       out_y;
  logic                out_last;

  modport master (
    output out_valid, out_ctr, out_x, out_y, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ctr, out_x, out_y, out_last,
    output out_ready
  );
endinterface

// File: rtl/mandelbrot_lanes.sv
// mandelbrot_lanes: LANES parallel escape-time engines on horizontally
// adjacent pixels, streaming quantised counts in raster order.
// Fixed point: signed BITWIDTH bits with BITWIDTH-3 fraction bits.
// Each lane step is z <- z^2 + c; a lane escapes when |z|^2 > 4 (size)
// or when the next z does not fit in BITWIDTH bits (overflow).
// Optional feature: define MANDELBROT_JULIA_EN to enable Julia mode.
module mandelbrot_lanes #(
  parameter int unsigned BITWIDTH = 10,
  parameter int unsigned CTRWIDTH = 7,
  parameter int unsigned OUTWIDTH = 4,
  parameter int unsigned LANES    = 4,
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 240
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_run,
  output logic                        o_busy,
  output logic                        o_frame_done,
  input  logic [CTRWIDTH-1:0]         i_max_ctr,
  input  logic [$clog2(CTRWIDTH)-1:0] i_ctr_shift,
  input  logic [BITWIDTH-1:0]         i_step,
  input  logic [BITWIDTH-1:0]         i_cr_offset,
  input  logic [BITWIDTH-1:0]         i_ci_offset,
  input  logic                        i_julia,
  input  logic [BITWIDTH-1:0]         i_jr,
  input  logic [BITWIDTH-1:0]         i_ji,
  mandelbrot_lanes_if.master          o_pix
);
  localparam int unsigned FRAC = BITWIDTH - 3;
  localparam int unsigned EW   = 2 * BITWIDTH + 2;
  localparam int unsigned MW   = 2 * BITWIDTH;
  localparam int unsigned SW   = $clog2(CTRWIDTH);
  localparam int unsigned XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned QMAX = (1 << OUTWIDTH) - 1;

  localparam logic signed [EW-1:0] C_LIM = EW'(4) << (2 * FRAC);
  localparam logic signed [EW-1:0] C_MAX = EW'((1 << (BITWIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] C_MIN = EW'(-(1 << (BITWIDTH - 1)));

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  // Frame parameters latched at start
  logic [CTRWIDTH-1:0] r_max;
  logic [SW-1:0]       r_shift;
  logic [BITWIDTH-1:0] r_step;
  logic [BITWIDTH-1:0] r_cr_off;
  logic [BITWIDTH-1:0] r_cr_base;
  logic [BITWIDTH-1:0] r_ci_row;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
`ifdef MANDELBROT_JULIA_EN
  logic                r_julia;
  logic [BITWIDTH-1:0] r_jr;
  logic [BITWIDTH-1:0] r_ji;
`else
  logic                w_unused_julia;
  assign w_unused_julia = ^{i_julia, i_jr, i_ji};
`endif

  // Per-lane engine state
  logic signed [BITWIDTH-1:0] r_zr [LANES];
  logic signed [BITWIDTH-1:0] r_zi [LANES];
  logic signed [BITWIDTH-1:0] r_cr [LANES];
  logic signed [BITWIDTH-1:0] r_ci [LANES];
  logic [CTRWIDTH-1:0]        r_ctr [LANES];
  logic [LANES-1:0]           r_frozen;
  logic [LW-1:0]              r_lane;

  // Registered outputs
  logic                r_busy;
  logic                r_frame_done;
  logic                r_out_valid;
  logic [OUTWIDTH-1:0] r_out_ctr;
  logic [XW-1:0]       r_out_x;
  logic [YW-1:0]       r_out_y;
  logic                r_out_last;

  // Lane ALU results and pixel offsets
  logic [BITWIDTH-1:0]        w_koff [LANES];
  logic signed [BITWIDTH-1:0] w_nr [LANES];
  logic signed [BITWIDTH-1:0] w_ni [LANES];
  logic [LANES-1:0]           w_frz;
  logic                       w_all_done;

  // FSM strobes
  logic          w_start, w_load, w_drain_go, w_xfer, w_grp_end;
  logic          w_row_end, w_last_grp;
  logic [LW-1:0] w_sel;
  logic [BITWIDTH-1:0] w_grp_step;

  assign w_grp_step = BITWIDTH'(LANES) * r_step;
  assign w_row_end  = (32'(r_x) + LANES == WIDTH);
  assign w_last_grp = w_row_end && (r_y == YW'(HEIGHT - 1));
  assign w_sel      = w_drain_go ? '0 : r_lane + LW'(1);
  assign w_all_done = &(r_frozen | w_frz);

  // One z^2 + c step per lane with escape/overflow flags on the current z
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [MW-1:0] w_zr_e, w_zi_e, w_rr, w_ii, w_ri;
    logic signed [EW-1:0] w_mag, w_re, w_im;
    logic                 w_size, w_ovf;

    assign w_koff[g] = BITWIDTH'(g) * r_step;
    assign w_zr_e    = MW'(r_zr[g]);
    assign w_zi_e    = MW'(r_zi[g]);
    assign w_rr      = w_zr_e * w_zr_e;
    assign w_ii      = w_zi_e * w_zi_e;
    assign w_ri      = w_zr_e * w_zi_e;
    assign w_mag     = EW'(w_rr) + EW'(w_ii);
    assign w_re      = ((EW'(w_rr) - EW'(w_ii)) >>> FRAC) + EW'(r_cr[g]);
    assign w_im      = ((EW'(w_ri) <<< 1) >>> FRAC) + EW'(r_ci[g]);
    assign w_size    = (w_mag > C_LIM);
    assign w_ovf     = (w_re > C_MAX) || (w_re < C_MIN) ||
                       (w_im > C_MAX) || (w_im < C_MIN);
    assign w_nr[g]   = BITWIDTH'(w_re);
    assign w_ni[g]   = BITWIDTH'(w_im);
    assign w_frz[g]  = !r_frozen[g] && (w_size || w_ovf || (r_ctr[g] == r_max));
  end

  function automatic logic [OUTWIDTH-1:0] quant(input logic [CTRWIDTH-1:0] c,
                                               input logic [SW-1:0] s);
    logic [CTRWIDTH-1:0] v;
    v = c >> s;
    if (32'(v) > QMAX) return '1;
    return OUTWIDTH'(v);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_drain_go  = 1'b0;
    w_xfer      = 1'b0;
    w_grp_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        if (w_all_done) begin
          w_drain_go  = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_out_valid && o_pix.out_ready) begin
          w_xfer = 1'b1;
          if (r_lane == LW'(LANES - 1)) begin
            w_grp_end   = 1'b1;
            w_state_nxt = w_last_grp ? S_IDLE : S_LOAD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: parameter latch, lane engines, drain sequencing, outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_ctr    <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_last   <= 1'b0;
      r_lane       <= '0;
      r_frozen     <= '1;
      r_max        <= '0;
      r_shift      <= '0;
      r_step       <= '0;
      r_cr_off     <= '0;
      r_cr_base    <= '0;
      r_ci_row     <= '0;
      r_x          <= '0;
      r_y          <= '0;
`ifdef MANDELBROT_JULIA_EN
      r_julia      <= 1'b0;
      r_jr         <= '0;
      r_ji         <= '0;
`endif
      for (int k = 0; k < LANES; k++) begin
        r_zr[k]  <= '0;
        r_zi[k]  <= '0;
        r_cr[k]  <= '0;
        r_ci[k]  <= '0;
        r_ctr[k] <= '0;
      end
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_grp_end && w_last_grp;

      if (w_start) begin
        r_max     <= i_max_ctr;
        r_shift   <= i_ctr_shift;
        r_step    <= i_step;
        r_cr_off  <= i_cr_offset;
        r_cr_base <= i_cr_offset;
        r_ci_row  <= i_ci_offset;
        r_x       <= '0;
        r_y       <= '0;
`ifdef MANDELBROT_JULIA_EN
        r_julia   <= i_julia;
        r_jr      <= i_jr;
        r_ji      <= i_ji;
`endif
      end

      if (w_load) begin
        r_frozen <= '0;
        for (int k = 0; k < LANES; k++) begin
          r_ctr[k] <= '0;
`ifdef MANDELBROT_JULIA_EN
          if (r_julia) begin
            r_zr[k] <= r_cr_base + w_koff[k];
            r_zi[k] <= r_ci_row;
            r_cr[k] <= r_jr;
            r_ci[k] <= r_ji;
          end else begin
            r_zr[k] <= '0;
            r_zi[k] <= '0;
            r_cr[k] <= r_cr_base + w_koff[k];
            r_ci[k] <= r_ci_row;
          end
`else
          r_zr[k] <= '0;
          r_zi[k] <= '0;
          r_cr[k] <= r_cr_base + w_koff[k];
          r_ci[k] <= r_ci_row;
`endif
        end
      end

      if (r_state == S_ITER) begin
        for (int k = 0; k < LANES; k++) begin
          if (w_frz[k]) begin
            r_frozen[k] <= 1'b1;
          end else if (!r_frozen[k]) begin
            r_zr[k]  <= w_nr[k];
            r_zi[k]  <= w_ni[k];
            r_ctr[k] <= r_ctr[k] + CTRWIDTH'(1);
          end
        end
      end

      if (w_drain_go || (w_xfer && !w_grp_end)) begin
        r_lane      <= w_sel;
        r_out_valid <= 1'b1;
        r_out_ctr   <= quant(r_ctr[w_sel], r_shift);
        r_out_x     <= r_x + XW'(w_sel);
        r_out_y     <= r_y;
        r_out_last  <= w_last_grp && (w_sel == LW'(LANES - 1));
      end else if (w_grp_end) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        if (w_row_end) begin
          r_x       <= '0;
          r_cr_base <= r_cr_off;
          r_y       <= r_y + YW'(1);
          r_ci_row  <= r_ci_row + r_step;
        end else begin
          r_x       <= r_x + XW'(LANES);
          r_cr_base <= r_cr_base + w_grp_step;
        end
      end
    end
  end

  assign o_busy          = r_busy;
  assign o_frame_done    = r_frame_done;
  assign o_pix.out_valid = r_out_valid;
  assign o_pix.out_ctr   = r_out_ctr;
  assign o_pix.out_x     = r_out_x;
  assign o_pix.out_y     = r_out_y;
  assign o_pix.out_last  = r_out_last;
endmodule

// File: doc/mandelbrot_lanes.md
# mandelbrot_lanes

Parametrised multi-lane successor to the single-pixel Mandelbrot iterator. It runs `LANES` escape-time engines in parallel on horizontally adjacent pixels, each built on the existing `mandelbrot_alu`. Results stream out in raster order over a valid/ready handshake, with saturating count quantisation. Julia-set mode is an optional build feature. It sits between the frame controller, which supplies run and view parameters, and the pixel buffer/VGA path, which consumes pixels.

## Interface
- `BITWIDTH`, 10: fixed-point width of c/z, in the `mandelbrot_alu` format.
- `CTRWIDTH`, 7: iteration counter width.
- `OUTWIDTH`, 4: output count width.
- `LANES`, 4: parallel engines. `WIDTH` must be a multiple of `LANES`.
- `WIDTH`, 320 / `HEIGHT`, 240: frame size in pixels.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start frame; sampled only in IDLE.
- `busy` out 1: high from LOAD through the final handshake.
- `frame_done` out 1: one-cycle pulse after the final pixel handshake.
- `max_ctr` in CTRWIDTH: iteration limit.
- `ctr_shift` in $clog2(CTRWIDTH): right shift applied before quantisation.
- `step` in BITWIDTH: pixel pitch, in both x and y.
- `cr_offset`, `ci_offset` in BITWIDTH: top-left coordinate.
- `julia` in 1; `jr`, `ji` in BITWIDTH: Julia mode select and constant.
- `out_valid` out 1 / `out_ready` in 1: pixel handshake.
- `out_ctr` out OUTWIDTH: quantised count.
- `out_x` out $clog2(WIDTH); `out_y` out $clog2(HEIGHT): pixel position.
- `out_last` out 1: asserted with the final pixel of the frame.

## Operation
- **FSM states:** IDLE → LOAD → ITER → DRAIN → (LOAD | IDLE).
- **IDLE:**
  - `run`=1 latches `max_ctr`, `ctr_shift`, `step`, `cr_offset`, `ci_offset`, `julia`, `jr`, `ji`.
  - Sets x=0, y=0, cr_base=cr_offset, ci_row=ci_offset.
  - Goes to LOAD.
- **LOAD (1 cycle):** lane k pixel coordinate is p_k = (cr_base + k·step, ci_row).
  - Mandelbrot mode: c = p_k, z = 0.
  - Julia mode: z = p_k, c = (jr, ji).
  - All lane counters cleared; all lanes active.
- **ITER:** each active lane checks its ALU flags on the current z every cycle.
  - Lane freezes when `size` or `overflow` is set, or when ctr == `max_ctr`; it records ctr.
  - Otherwise z ← ALU output and ctr ← ctr+1.
  - Frozen lanes hold their state.
  - Leave for DRAIN the cycle after all lanes are frozen.
- **DRAIN:** presents lanes 0..LANES-1 in order, one pixel per accepted handshake.
  - out_x = x+k, out_y = y.
  - out_ctr = (ctr >> ctr_shift), saturated to 2^OUTWIDTH−1.
- **After lane LANES-1 is accepted:**
  - x ← x+LANES, cr_base ← cr_base + LANES·step.
  - If x+LANES == WIDTH: x ← 0, cr_base ← cr_offset, y ← y+1, ci_row ← ci_row + step.
  - If that was the last group, `out_last` is high on the final pixel. Go to IDLE and pulse `frame_done` on the next cycle.
  - Otherwise go to LOAD.
- **Arithmetic:** coordinate adds and the k·step products are truncated to BITWIDTH and wrap mod 2^BITWIDTH. The counter never exceeds `max_ctr`.
- **Boundary cases:**
  - `max_ctr`=0: every lane freezes in the first ITER cycle with count 0.
  - `run` while not in IDLE is ignored.
  - Input changes mid-frame are ignored because the inputs are latched.

## Timing
- **Reset values:** `busy`, `frame_done`, `out_valid`, `out_ctr`, `out_x`, `out_y`, `out_last` all 0; state IDLE.
- **Reset mid-frame:** outputs return to reset values on the next edge. All in-flight pixels are discarded and no `frame_done` is produced.
- **Start latency:** `run` high at edge N gives LOAD in cycle N+1 and ITER from N+2.
- **Group latency:** 1 (LOAD) + (max frozen lane ctr + 1) ITER cycles. First `out_valid` follows on the next cycle.
- **Handshake:**
  - A transfer occurs on any edge with `out_valid` && `out_ready`.
  - While `out_valid`=1 and `out_ready`=0, all out_* are held stable.
  - `out_valid` never drops without a transfer except on reset.
  - With `out_ready` held high, DRAIN takes exactly LANES cycles.

## Configuration
- **`MANDELBROT_JULIA_EN`**
  - Defined: Julia mode is available as described above.
  - Undefined: `julia`, `jr`, `ji` remain ports but are ignored, the mode is always Mandelbrot, and no Julia muxing logic is synthesised.

## Test plan
Bench parameters: LANES=4, WIDTH=8, HEIGHT=2, CTRWIDTH=7, OUTWIDTH=4.
- **Reset values:** assert reset → all outputs 0. Then `run`, `max_ctr`=0, `out_ready`=1 → 16 pixels with out_ctr=0, x 0..7, y 0..1, `out_last` only on (7,1), one `frame_done` pulse, `busy` falls.
- **Saturation and shift:** cr_offset=ci_offset=step=0, `max_ctr`=20.
  - ctr_shift=0 → every out_ctr=15 (saturated).
  - ctr_shift=2 → every out_ctr=5.
  - Each group takes 1+21 cycles before out_valid.
- **Backpressure:** `out_ready`=0 for 5 cycles mid-DRAIN → out_valid/out_ctr/out_x/out_y stable. Afterwards all 16 pixels arrive in order with no loss or duplication.
- **Reset mid-ITER:** assert reset during ITER → next cycle busy=0, out_valid=0. A fresh `run` then restarts at (0,0) and produces a full 16-pixel frame.
- **Julia mode (macro defined):**
  - julia=1, offsets 0, step 0, (jr,ji)=K → counts equal Mandelbrot mode with cr_offset/ci_offset=K.
  - julia=1, offsets=K, (jr,ji)=0 → counts match the golden model.
  - Macro undefined → `julia` has no effect.
- **Run while busy:** pulse `run` during ITER/DRAIN → no restart; the frame completes with exactly 16 pixels and one `frame_done`.
